lives_hud_controller: RTL and testbench

- Consumer end of the lives-counter interface. Takes the registered lives digit and the no-life flag from the lives counter.
- Produces the per-heart visibility mask for the HUD drawer and animates a lost heart by blinking it on frame boundaries.
- Runs the game-over hold, then issues a restart request to the top-level game FSM using a req/ack handshake.

---
 rtl/lives_hud_controller.sv | 190 +++++++++++++++++++
 tb/tb_lives_hud_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/lives_hud_controller.sv
// HUD side of the lives counter: heart visibility mask, lost-heart blink, game-over hold and restart handshake.
// Optional macro LIVES_SOUND_EN adds the sound_trig output.
module lives_hud_controller #(
   parameter int MAX_LIVES      = 3,
   parameter int BLINK_PERIOD   = 8,
   parameter int BLINK_TOGGLES  = 6,
   parameter int GAMEOVER_DELAY = 60
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 startOfFrame,
   input  logic [3:0]           lives,
   input  logic                 no_life,
   input  logic                 restart_ack,
   output logic [MAX_LIVES-1:0] heart_mask,
   output logic                 life_lost,
   output logic                 game_over,
`ifdef LIVES_SOUND_EN
   output logic                 sound_trig,
`endif
   output logic                 restart_req
);

   localparam int CNT_MAX = (BLINK_PERIOD > GAMEOVER_DELAY) ? BLINK_PERIOD : GAMEOVER_DELAY;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int TOG_W   = $clog2(BLINK_TOGGLES + 1);
   localparam int IDX_W   = (MAX_LIVES > 1) ? $clog2(MAX_LIVES) : 1;

   typedef enum logic [1:0] {
      IDLE_ST     = 2'd0,
      BLINK_ST    = 2'd1,
      GAMEOVER_ST = 2'd2,
      RESTART_ST  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [3:0]           lives_dly_q;
   logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
   logic [TOG_W-1:0]     toggle_cnt_q, toggle_cnt_d;
   logic [IDX_W-1:0]     blink_idx_q, blink_idx_d;
   logic                 blink_on_q, blink_on_d;
   logic [MAX_LIVES-1:0] heart_mask_q, heart_mask_d;
   logic                 life_lost_q, life_lost_d;
   logic                 game_over_q, game_over_d;
   logic                 restart_req_q, restart_req_d;
   logic                 decrement;
   logic [MAX_LIVES-1:0] base_mask_w;
   logic [MAX_LIVES-1:0] blink_bit_w;

   function automatic logic [MAX_LIVES-1:0] base_mask(input logic [3:0] l);
      logic [MAX_LIVES-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_LIVES; i++) begin
         m[i] = (i < int'(l));
      end
      return m;
   endfunction

   // A lives value beyond the icon count blinks the top heart.
   function automatic logic [IDX_W-1:0] clamp_idx(input logic [3:0] l);
      if (int'(l) >= MAX_LIVES) begin
         return IDX_W'(MAX_LIVES - 1);
      end
      return l[IDX_W-1:0];
   endfunction

   assign decrement   = (lives < lives_dly_q);
   assign base_mask_w = base_mask(lives);

   always_comb begin
      state_d       = state_q;
      frame_cnt_d   = frame_cnt_q;
      toggle_cnt_d  = toggle_cnt_q;
      blink_idx_d   = blink_idx_q;
      blink_on_d    = blink_on_q;
      life_lost_d   = 1'b0;
      heart_mask_d  = base_mask_w;
      blink_bit_w   = '0;

      case (state_q)
         IDLE_ST, BLINK_ST: begin
            // A decrement has priority over frame counting and over no_life.
            if (decrement) begin
               life_lost_d  = 1'b1;
               blink_idx_d  = clamp_idx(lives);
               blink_on_d   = 1'b1;
               frame_cnt_d  = '0;
               toggle_cnt_d = '0;
               state_d      = BLINK_ST;
            end else if (state_q == IDLE_ST) begin
               if (no_life) begin
                  frame_cnt_d = '0;
                  state_d     = GAMEOVER_ST;
               end
            end else if (startOfFrame) begin
               if (frame_cnt_q == CNT_W'(BLINK_PERIOD - 1)) begin
                  frame_cnt_d = '0;
                  blink_on_d  = ~blink_on_q;
                  if (toggle_cnt_q == TOG_W'(BLINK_TOGGLES - 1)) begin
                     toggle_cnt_d = '0;
                     state_d      = no_life ? GAMEOVER_ST : IDLE_ST;
                  end else begin
                     toggle_cnt_d = toggle_cnt_q + 1'b1;
                  end
               end else begin
                  frame_cnt_d = frame_cnt_q + 1'b1;
               end
            end
         end
         GAMEOVER_ST: begin
            if (startOfFrame) begin
               if (frame_cnt_q == CNT_W'(GAMEOVER_DELAY - 1)) begin
                  frame_cnt_d = '0;
                  state_d     = RESTART_ST;
               end else begin
                  frame_cnt_d = frame_cnt_q + 1'b1;
               end
            end
         end
         RESTART_ST: begin
            if (restart_ack) begin
               state_d = IDLE_ST;
            end
         end
         default: state_d = IDLE_ST;
      endcase

      // Outputs are registered from the next state so they track state_q exactly.
      if (blink_on_d) begin
         blink_bit_w = MAX_LIVES'(1) << blink_idx_d;
      end
      case (state_d)
         BLINK_ST:                heart_mask_d = base_mask_w | blink_bit_w;
         GAMEOVER_ST, RESTART_ST: heart_mask_d = '0;
         default:                 heart_mask_d = base_mask_w;
      endcase
      game_over_d   = (state_d == GAMEOVER_ST) || (state_d == RESTART_ST);
      restart_req_d = (state_d == RESTART_ST);
   end

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state_q       <= IDLE_ST;
         lives_dly_q   <= 4'(MAX_LIVES);
         frame_cnt_q   <= '0;
         toggle_cnt_q  <= '0;
         blink_on_q    <= 1'b0;
         heart_mask_q  <= '1;
         life_lost_q   <= 1'b0;
         game_over_q   <= 1'b0;
         restart_req_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         lives_dly_q   <= lives;
         frame_cnt_q   <= frame_cnt_d;
         toggle_cnt_q  <= toggle_cnt_d;
         blink_on_q    <= blink_on_d;
         heart_mask_q  <= heart_mask_d;
         life_lost_q   <= life_lost_d;
         game_over_q   <= game_over_d;
         restart_req_q <= restart_req_d;
      end
   end

   always_ff @(posedge clk) begin
      blink_idx_q <= blink_idx_d;
   end

   assign heart_mask  = heart_mask_q;
   assign life_lost   = life_lost_q;
   assign game_over   = game_over_q;
   assign restart_req = restart_req_q;

`ifdef LIVES_SOUND_EN
   logic sound_trig_q, sound_trig_d;

   assign sound_trig_d = life_lost_d || ((state_d == GAMEOVER_ST) && (state_q != GAMEOVER_ST));

   always_ff @(posedge clk) begin
      if (!resetN) begin
         sound_trig_q <= 1'b0;
      end else begin
         sound_trig_q <= sound_trig_d;
      end
   end

   assign sound_trig = sound_trig_q;
`endif

endmodule

// File: tb/tb_lives_hud_controller.sv
// Directed bench for lives_hud_controller with default parameters; frames are 4 clocks long.
module tb_lives_hud_controller;

   logic       clk = 1'b0;
   logic       resetN, sof, no_life, ack;
   logic [3:0] lives;
   logic [2:0] mask;
   logic       ll, go, rr;
   int         total = 0;
   int         passed = 0;
   int         ll_cnt = 0;
   int         ll_base;
`ifdef LIVES_SOUND_EN
   logic       st;
   int         st_cnt = 0;
   int         st_base;
`endif

   lives_hud_controller dut (
      .clk          (clk),
      .resetN       (resetN),
      .startOfFrame (sof),
      .lives        (lives),
      .no_life      (no_life),
      .restart_ack  (ack),
      .heart_mask   (mask),
      .life_lost    (ll),
      .game_over    (go),
`ifdef LIVES_SOUND_EN
      .sound_trig   (st),
`endif
      .restart_req  (rr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (ll === 1'b1) ll_cnt++;
`ifdef LIVES_SOUND_EN
      if (st === 1'b1) st_cnt++;
`endif
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic frame;
      sof = 1'b1;
      tick();
      sof = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_reset;
      lives = 4'd3; no_life = 1'b0; ack = 1'b0; sof = 1'b0; resetN = 1'b0;
      tick(); tick();
      total++; if (mask !== 3'b111) $display("FAIL reset_mask: got %b expected 111", mask); else passed++;
      total++; if (ll !== 1'b0) $display("FAIL reset_life_lost: got %b expected 0", ll); else passed++;
      total++; if (go !== 1'b0) $display("FAIL reset_game_over: got %b expected 0", go); else passed++;
      total++; if (rr !== 1'b0) $display("FAIL reset_restart_req: got %b expected 0", rr); else passed++;
      resetN = 1'b1;
      ll_base = ll_cnt;
      repeat (100) frame();
      total++; if (ll_cnt - ll_base !== 0) $display("FAIL idle_no_pulse: got %0d pulses expected 0", ll_cnt - ll_base); else passed++;
      total++; if (mask !== 3'b111) $display("FAIL idle_mask: got %b expected 111", mask); else passed++;
      total++; if (go !== 1'b0 || rr !== 1'b0) $display("FAIL idle_flags: got go=%b req=%b expected 0 0", go, rr); else passed++;
   endtask

   task automatic test_blink;
      logic [2:0] exp;
      ll_base = ll_cnt;
      lives = 4'd2;
      tick();
      total++; if (ll !== 1'b1) $display("FAIL blink_pulse: got %b expected 1", ll); else passed++;
      total++; if (mask !== 3'b111) $display("FAIL blink_start_mask: got %b expected 111", mask); else passed++;
      tick();
      total++; if (ll !== 1'b0) $display("FAIL blink_pulse_end: got %b expected 0", ll); else passed++;
      for (int k = 1; k <= 48; k++) begin
         frame();
         exp = (k < 48 && ((k / 8) % 2 == 0)) ? 3'b111 : 3'b011;
         total++; if (mask !== exp) $display("FAIL blink_mask_f%0d: got %b expected %b", k, mask, exp); else passed++;
      end
      lives = 4'd3;
      tick(); tick();
      total++; if (mask !== 3'b111) $display("FAIL increase_mask: got %b expected 111", mask); else passed++;
      total++; if (ll_cnt - ll_base !== 1) $display("FAIL blink_pulse_count: got %0d expected 1", ll_cnt - ll_base); else passed++;
   endtask

   task automatic test_double_loss;
      logic [2:0] exp;
      ll_base = ll_cnt;
      lives = 4'd2;
      tick();
      repeat (10) frame();
      total++; if (mask !== 3'b011) $display("FAIL double_mid_mask: got %b expected 011", mask); else passed++;
      lives = 4'd1;
      tick();
      total++; if (ll !== 1'b1) $display("FAIL double_pulse: got %b expected 1", ll); else passed++;
      total++; if (mask !== 3'b011) $display("FAIL double_start_mask: got %b expected 011", mask); else passed++;
      for (int k = 1; k <= 48; k++) begin
         frame();
         exp = (k < 48 && ((k / 8) % 2 == 0)) ? 3'b011 : 3'b001;
         total++; if (mask !== exp) $display("FAIL double_mask_f%0d: got %b expected %b", k, mask, exp); else passed++;
      end
      total++; if (ll_cnt - ll_base !== 2) $display("FAIL double_pulse_count: got %0d expected 2", ll_cnt - ll_base); else passed++;
   endtask

   task automatic test_gameover;
      logic [2:0] exp;
      ll_base = ll_cnt;
`ifdef LIVES_SOUND_EN
      st_base = st_cnt;
`endif
      lives = 4'd0; no_life = 1'b1;
      tick();
      total++; if (ll !== 1'b1) $display("FAIL last_pulse: got %b expected 1", ll); else passed++;
      total++; if (mask !== 3'b001 || go !== 1'b0) $display("FAIL last_start: got mask=%b go=%b expected 001 0", mask, go); else passed++;
      for (int k = 1; k <= 48; k++) begin
         frame();
         exp = (k < 48 && ((k / 8) % 2 == 0)) ? 3'b001 : 3'b000;
         total++; if (mask !== exp) $display("FAIL last_mask_f%0d: got %b expected %b", k, mask, exp); else passed++;
         total++; if (go !== (k >= 48)) $display("FAIL last_go_f%0d: got %b expected %b", k, go, (k >= 48)); else passed++;
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      total++; if (go !== 1'b1 || rr !== 1'b0) $display("FAIL early_ack: got go=%b req=%b expected 1 0", go, rr); else passed++;
      for (int k = 1; k <= 60; k++) begin
         frame();
         total++; if (rr !== (k == 60)) $display("FAIL hold_req_f%0d: got %b expected %b", k, rr, (k == 60)); else passed++;
      end
      for (int c = 0; c < 20; c++) begin
         tick();
         total++; if (rr !== 1'b1 || go !== 1'b1) $display("FAIL req_held_c%0d: got req=%b go=%b expected 1 1", c, rr, go); else passed++;
      end
      ack = 1'b1; no_life = 1'b0; lives = 4'd3;
      tick();
      ack = 1'b0;
      total++; if (rr !== 1'b0 || go !== 1'b0) $display("FAIL ack_drop: got req=%b go=%b expected 0 0", rr, go); else passed++;
      total++; if (mask !== 3'b111) $display("FAIL ack_mask: got %b expected 111", mask); else passed++;
      tick();
      total++; if (ll_cnt - ll_base !== 1) $display("FAIL last_pulse_count: got %0d expected 1", ll_cnt - ll_base); else passed++;
`ifdef LIVES_SOUND_EN
      total++; if (st_cnt - st_base !== 2) $display("FAIL sound_count: got %0d expected 2", st_cnt - st_base); else passed++;
`endif
   endtask

   task automatic test_reset_mid;
      no_life = 1'b1;
      tick(); tick();
      total++; if (go !== 1'b1 || mask !== 3'b000) $display("FAIL idle_nolife: got go=%b mask=%b expected 1 000", go, mask); else passed++;
      repeat (60) frame();
      total++; if (rr !== 1'b1) $display("FAIL mid_req: got %b expected 1", rr); else passed++;
      ack = 1'b1; resetN = 1'b0; no_life = 1'b0;
      tick();
      total++; if (mask !== 3'b111) $display("FAIL mid_reset_mask: got %b expected 111", mask); else passed++;
      total++; if (go !== 1'b0 || rr !== 1'b0 || ll !== 1'b0) $display("FAIL mid_reset_flags: got go=%b req=%b ll=%b expected 0 0 0", go, rr, ll); else passed++;
      resetN = 1'b1;
      tick();
      total++; if (rr !== 1'b0 || go !== 1'b0) $display("FAIL post_reset_ack: got req=%b go=%b expected 0 0", rr, go); else passed++;
      tick();
      total++; if (rr !== 1'b0) $display("FAIL post_reset_req: got %b expected 0", rr); else passed++;
      ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_blink();
      test_double_loss();
      test_gameover();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
